// File: rtl/accum_frame_unit.sv
// accum_frame_unit
//   Pipelined signed frame accumulator with per-sample add/subtract.
//   It sums each framed sample stream and presents the frame total on a
//   valid/ready port, together with carry/borrow and sticky overflow.
//
//   Stage 1 registers the sign-extended sample and its control bits.
//   Stage 2 performs the add/sub and updates acc_out, co and ovf.
//   A three-state FSM (RUN -> FLUSH -> PRESENT) frames the results.
//
//   Optional build macro: ACCUM_SATURATE_EN
//     defined   : an overflowing update clamps acc to the signed max/min.
//     undefined : acc wraps modulo 2^ACC_W.
//     ovf flags the overflow in both builds.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   in_valid/in_ready    sample handshake
//   in_data              signed sample (DATA_W bits)
//   in_sub               0: acc + x, 1: acc - x
//   in_load              first sample of a frame (the update starts from 0)
//   in_last              final sample of a frame
//   out_valid/out_ready  frame-result handshake
//   acc_out              accumulator (the frame total while out_valid)
//   co                   carry (add) or borrow (sub) of the most recent update
//   ovf                  sticky signed overflow for the current frame
module accum_frame_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sub,
    input  logic              in_load,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              co,
    output logic              ovf
);

    generate
        if (ACC_W < DATA_W) begin : g_bad_width
            $error("accum_frame_unit: ACC_W must be >= DATA_W");
        end
    endgenerate

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {RUN, FLUSH, PRESENT} state_t;

    typedef struct packed {
        logic [ACC_W-1:0] x;
        logic             sub;
        logic             load;
        logic             last;
    } s1_t;

    state_t           state, state_nxt;
    s1_t              s1;
    logic             s1_vld;
    logic             accept;
    logic             handshake;

    logic [ACC_W-1:0] op_a, op_b, raw, res;
    logic [ACC_W:0]   sum;
    logic             carry, ovf_now;

    assign accept    = in_valid && (state == RUN);
    assign handshake = (state == PRESENT) && out_ready;

    // FSM next state and port flags
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                if (accept && in_last) state_nxt = FLUSH;
            end
            // Stage 1 holds the last sample; it lands in acc this cycle
            FLUSH: begin
                if (s1_vld && s1.last) state_nxt = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Stage 2 adder: subtract is acc + ~x + 1 through the same carry chain
    always_comb begin
        op_a    = s1.load ? '0 : acc_out;
        op_b    = s1.sub ? ~s1.x : s1.x;
        sum     = {1'b0, op_a} + {1'b0, op_b} + (ACC_W+1)'(s1.sub);
        raw     = sum[ACC_W-1:0];
        carry   = sum[ACC_W];
        // The operands agree in sign but the result does not
        ovf_now = (op_a[ACC_W-1] == op_b[ACC_W-1]) && (raw[ACC_W-1] != op_a[ACC_W-1]);
`ifdef ACCUM_SATURATE_EN
        // Overflow can only occur with equal operand signs, so op_a's sign gives its direction
        res     = ovf_now ? (op_a[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
        res     = raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            s1      <= '0;
            s1_vld  <= 1'b0;
            acc_out <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state  <= state_nxt;
            s1_vld <= accept;
            if (accept) begin
                s1.x    <= ACC_W'($signed(in_data));
                s1.sub  <= in_sub;
                s1.load <= in_load;
                s1.last <= in_last;
            end
            // In PRESENT, stage 1 is always empty, so the two branches never compete
            if (handshake) begin
                acc_out <= '0;
                co      <= 1'b0;
                ovf     <= 1'b0;
            end else if (s1_vld) begin
                acc_out <= res;
                co      <= s1.sub ? ~carry : carry;
                ovf     <= (ovf && !s1.load) || ovf_now;
            end
        end
    end

endmodule

// File: tb/tb_accum_frame_unit.sv
// Scoreboard bench for accum_frame_unit.
// Two instances share the same stimulus: a (DATA_W=16, ACC_W=32) and b (16/16).
// Instance b exercises overflow at the narrow width.
// The stimulus process updates a value-level reference model and queues each frame's expected result.
// The monitor compares every presented result against the queue head.
module tb_accum_frame_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0, in_load = 1'b0, in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;

    logic        rdy_a, vld_a, co_a, ovf_a;
    logic [31:0] acc_a;
    logic        rdy_b, vld_b, co_b, ovf_b;
    logic [15:0] acc_b;

    always #5 clk = ~clk;

    accum_frame_unit #(.DATA_W(16), .ACC_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_sub(in_sub), .in_load(in_load), .in_last(in_last),
        .out_valid(vld_a), .out_ready(out_ready), .acc_out(acc_a), .co(co_a), .ovf(ovf_a));

    accum_frame_unit #(.DATA_W(16), .ACC_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_sub(in_sub), .in_load(in_load), .in_last(in_last),
        .out_valid(vld_b), .out_ready(out_ready), .acc_out(acc_b), .co(co_b), .ovf(ovf_b));

    typedef struct {
        logic [31:0] acc;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t   qa[$], qb[$];
    longint m_acc[2];
    bit     m_co[2], m_ovf[2];
    int     total = 0, bad = 0;
    int     rdy_mode = 0;   // 0: random out_ready, 1: hold low, 2: hold high
    bit     done = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Integer reference: exact signed sum, range check, then wrap or clamp
    task automatic upd_model(int i, int w, logic [15:0] d, bit sub, bit load);
        longint a, xs, r, mx, mn, md, ua, ux;
        bit     o;
        md = 64'sd1 <<< w;
        mx = (md >>> 1) - 1;
        mn = -(md >>> 1);
        a  = load ? 64'sd0 : m_acc[i];
        xs = longint'($signed(d));
        r  = sub ? a - xs : a + xs;
        o  = (r > mx) || (r < mn);
        ua = ((a % md) + md) % md;
        ux = ((xs % md) + md) % md;
        m_co[i] = sub ? (ua < ux) : (ua + ux >= md);
        if (o) begin
`ifdef ACCUM_SATURATE_EN
            r = (r > mx) ? mx : mn;
`else
            r = ((r % md) + md) % md;
            if (r > mx) r -= md;
`endif
        end
        m_ovf[i] = (load ? 1'b0 : m_ovf[i]) | o;
        m_acc[i] = r;
    endtask

    task automatic clr_model();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_co[i]  = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at the posedge+1 after the sample is accepted
    task automatic send(logic [15:0] d, bit sub, bit load, bit last);
        int     n = 0;
        longint va, vb;
        in_valid = 1'b1; in_data = d; in_sub = sub; in_load = load; in_last = last;
        while (!rdy_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy_a) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
        end
        upd_model(0, 32, d, sub, load);
        upd_model(1, 16, d, sub, load);
        if (last) begin
            va = m_acc[0];
            vb = m_acc[1];
            qa.push_back('{acc: va[31:0], co: m_co[0], ovf: m_ovf[0]});
            qb.push_back('{acc: {16'h0, vb[15:0]}, co: m_co[1], ovf: m_ovf[1]});
            clr_model();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_load = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!vld_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!vld_a) fail_now("out_valid_timeout");
    endtask

    // One forced handshake, then back to random back-pressure
    task automatic release_out();
        @(posedge clk); #1; rdy_mode = 2;
        @(posedge clk); #1; rdy_mode = 0;
    endtask

    task automatic monitor();
        bit hs_prev = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (hs_prev) begin
                chk("post_hs_acc", acc_a, 32'h0);
                chk("post_hs_rdy", 32'(rdy_a), 32'h1);
                chk("post_hs_vld", 32'(vld_a), 32'h0);
            end
            hs_prev = 1'b0;
            case (rdy_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(3) != 0);
            endcase
            if (vld_a || vld_b) begin
                if (qa.size() == 0 || qb.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    chk("a_acc", acc_a, qa[0].acc);
                    chk("a_co", 32'(co_a), 32'(qa[0].co));
                    chk("a_ovf", 32'(ovf_a), 32'(qa[0].ovf));
                    chk("b_acc", 32'(acc_b), qb[0].acc);
                    chk("b_co", 32'(co_b), 32'(qb[0].co));
                    chk("b_ovf", 32'(ovf_b), 32'(qb[0].ovf));
                    chk("vld_align", 32'(vld_b), 32'(vld_a));
                    if (out_ready) begin
                        void'(qa.pop_front());
                        void'(qb.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        logic [15:0] d;
        int          len, n;
        // Frame 3, 5, -2, with the latency checked around in_last
        rdy_mode = 1;
        send(16'd3, 0, 1, 0);
        send(16'd5, 0, 0, 0);
        send(16'hFFFE, 0, 0, 1);
        @(negedge clk);
        chk("lat_ready_low", 32'(rdy_a), 32'h0);
        chk("lat_n1_vld", 32'(vld_a), 32'h0);
        @(negedge clk);
        chk("lat_n2_vld", 32'(vld_a), 32'h1);
        chk("sum_6", acc_a, 32'd6);
        chk("sum_6_ovf", 32'(ovf_a), 32'h0);
        release_out();

        // 100 - 250 gives a borrow
        rdy_mode = 1;
        send(16'd100, 0, 1, 0);
        send(16'd250, 1, 0, 1);
        wait_out();
        chk("sub_acc", acc_a, 32'hFFFFFF6A);
        chk("sub_co", 32'(co_a), 32'h1);
        chk("sub_ovf", 32'(ovf_a), 32'h0);
        chk("sub_acc16", 32'(acc_b), 32'h0000FF6A);
        release_out();

        // 0x7FFF + 1 overflows at 16 bits only
        rdy_mode = 1;
        send(16'h7FFF, 0, 1, 0);
        send(16'h0001, 0, 0, 1);
        wait_out();
`ifdef ACCUM_SATURATE_EN
        chk("ovf16_acc", 32'(acc_b), 32'h00007FFF);
`else
        chk("ovf16_acc", 32'(acc_b), 32'h00008000);
`endif
        chk("ovf16_flag", 32'(ovf_b), 32'h1);
        chk("ovf32_acc", acc_a, 32'h00008000);
        chk("ovf32_flag", 32'(ovf_a), 32'h0);
        release_out();

        // A single-sample frame: 0 - (-32768)
        rdy_mode = 1;
        send(16'h8000, 1, 1, 1);
        wait_out();
        chk("neg_min_acc", acc_a, 32'h00008000);
        chk("neg_min_ovf", 32'(ovf_a), 32'h0);
        release_out();

        // 10 cycles of stall with in_valid pulses that must not be taken
        rdy_mode = 1;
        send(16'd11, 0, 1, 1);
        wait_out();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 1'(($urandom_range(1)));
            in_data = 16'($urandom);
            in_load = 1'b1;
            in_last = 1'b1;
            @(negedge clk);
            chk("stall_rdy", 32'(rdy_a), 32'h0);
            chk("stall_vld", 32'(vld_a), 32'h1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_load = 1'b0; in_last = 1'b0;
        release_out();
        send(16'd1, 0, 1, 1);

        // Reset during FLUSH drops the pending result
        send(16'd9, 0, 1, 0);
        send(16'd4, 0, 0, 1);
        rst_n = 1'b0;
        #2;
        chk("rst_flush_acc", acc_a, 32'h0);
        chk("rst_flush_vld", 32'(vld_a), 32'h0);
        chk("rst_flush_rdy", 32'(rdy_a), 32'h1);
        qa.delete();
        qb.delete();
        clr_model();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_vld", 32'(vld_a), 32'h0);
        end
        @(posedge clk); #1;
        send(16'd7, 0, 1, 1);

        // Random frames with occasional restarts and large values
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
                d = ($urandom_range(3) == 0) ? (16'h7000 | 16'($urandom)) : 16'($urandom);
                send(d, 1'($urandom_range(1)),
                     (k == 0) ? ($urandom_range(4) != 0) : ($urandom_range(9) == 0),
                     k == len - 1);
                if ($urandom_range(2) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end

        n = 0;
        while (qa.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (qa.size() != 0) fail_now("drain_timeout");
        done = 1'b1;
    endtask

    initial begin
        clr_model();
        #12;
        chk("rst_acc", acc_a, 32'h0);
        chk("rst_co", 32'(co_a), 32'h0);
        chk("rst_ovf", 32'(ovf_a), 32'h0);
        chk("rst_vld", 32'(vld_a), 32'h0);
        chk("rst_rdy", 32'(rdy_a), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fork
            monitor();
            stimulus();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
